// File: rtl/bsg_mcl_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bsg_mcl_request_scheduler
// Brief    : Round-robin, credit-gated arbiter feeding one endpoint request
//            FIFO, with a fence handshake that drains in-flight requests.
//            Optional statistics counters: define BSG_MCL_SCHED_STATS_EN.
// Revision : 1.0
// ============================================================================
module bsg_mcl_request_scheduler #(
  parameter int num_req_p         = 2,
  parameter int fifo_width_p      = 128,
  parameter int max_out_credits_p = 16,
  parameter int stat_width_p      = 32,
  localparam int credits_width_lp = $clog2(max_out_credits_p+1),
  localparam int id_width_lp      = $clog2(num_req_p)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_req_p-1:0]                      req_v_i,
  input  logic [num_req_p-1:0][fifo_width_p-1:0]    req_data_i,
  output logic [num_req_p-1:0]                      req_rdy_o,
  output logic                                      out_v_o,
  output logic [fifo_width_p-1:0]                   out_data_o,
  input  logic                                      out_rdy_i,
  input  logic [credits_width_lp-1:0]               out_credits_i,
  input  logic                                      fence_i,
  output logic                                      fence_done_o,
  output logic [id_width_lp-1:0]                    grant_id_o,
  output logic [num_req_p-1:0][stat_width_p-1:0]    issued_count_o,
  output logic [stat_width_p-1:0]                   credit_stall_count_o
);

  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_fence = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  logic [1:0]             r_state;
  logic [id_width_lp-1:0] r_last;
  logic                   r_sent;

  logic [1:0]             w_in_flight;
  logic                   w_slot_free;
  logic                   w_credit_ok;
  logic                   w_grant_en;
  logic                   w_xfer;
  logic                   w_found_hi;
  logic [id_width_lp-1:0] w_sel_hi;
  logic [id_width_lp-1:0] w_sel_lo;
  logic [id_width_lp-1:0] w_sel;

  // The held packet plus one just handed over (credit not yet taken by the
  // endpoint) are both already committed against out_credits_i.
  assign w_in_flight = {1'b0, out_v_o} + {1'b0, r_sent};
  assign w_slot_free = !out_v_o || out_rdy_i;
  assign w_credit_ok = out_credits_i > credits_width_lp'(w_in_flight);
  assign w_grant_en  = (r_state == c_st_run) && !fence_i && w_slot_free && w_credit_ok;
  assign w_xfer      = w_grant_en && (|req_v_i);

  // Two-pass priority search: lowest valid index above r_last wins, else the
  // lowest valid index at or below it (wrap-around).
  always_comb begin
    w_found_hi = 1'b0;
    w_sel_hi   = '0;
    w_sel_lo   = '0;
    for (int i = num_req_p-1; i >= 0; i--) begin
      if (req_v_i[i]) begin
        if (i > int'(r_last)) begin
          w_found_hi = 1'b1;
          w_sel_hi   = id_width_lp'(i);
        end else begin
          w_sel_lo   = id_width_lp'(i);
        end
      end
    end
  end

  assign w_sel        = w_found_hi ? w_sel_hi : w_sel_lo;
  assign req_rdy_o    = (w_xfer && !reset_i) ? (num_req_p'(1) << w_sel) : '0;
  assign fence_done_o = (r_state == c_st_done);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_v_o    <= 1'b0;
      out_data_o <= '0;
      grant_id_o <= '0;
      r_last     <= id_width_lp'(num_req_p-1);
      r_sent     <= 1'b0;
      r_state    <= c_st_run;
    end else begin
      if (w_xfer) begin
        out_v_o    <= 1'b1;
        out_data_o <= req_data_i[w_sel];
        grant_id_o <= w_sel;
        r_last     <= w_sel;
      end else if (out_rdy_i) begin
        out_v_o    <= 1'b0;
      end
      r_sent <= out_v_o && out_rdy_i;

      case (r_state)
        c_st_run:   if (fence_i) r_state <= c_st_fence;
        c_st_fence: if (!out_v_o && !r_sent &&
                        (out_credits_i == credits_width_lp'(max_out_credits_p)))
                      r_state <= c_st_done;
        c_st_done:  r_state <= c_st_run;
        default:    r_state <= c_st_run;
      endcase
    end
  end

`ifdef BSG_MCL_SCHED_STATS_EN
  logic [num_req_p-1:0][stat_width_p-1:0] r_issued;
  logic [stat_width_p-1:0]                r_stall;
  logic                                   w_stall;

  assign w_stall = (r_state == c_st_run) && !fence_i && (|req_v_i)
                   && w_slot_free && !w_credit_ok;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_issued <= '0;
      r_stall  <= '0;
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        if (w_xfer && (w_sel == id_width_lp'(i)))
          r_issued[i] <= r_issued[i] + stat_width_p'(1);
      end
      if (w_stall)
        r_stall <= r_stall + stat_width_p'(1);
    end
  end

  assign issued_count_o       = r_issued;
  assign credit_stall_count_o = r_stall;
`else
  assign issued_count_o       = '0;
  assign credit_stall_count_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_mcl_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_mcl_request_scheduler
// Brief    : Randomized scoreboard bench for bsg_mcl_request_scheduler.
// Revision : 1.0
// ============================================================================
module tb_bsg_mcl_request_scheduler;

  localparam int N    = 2;
  localparam int W    = 128;
  localparam int CRED = 16;
  localparam int SW   = 32;
  localparam int CW   = $clog2(CRED+1);
  localparam int IW   = $clog2(N);

  localparam int RUN = 0, FENCE = 1, DONE = 2;

  logic                   clk = 1'b0;
  logic                   reset_i = 1'b0;
  logic [N-1:0]           req_v_i = '0;
  logic [N-1:0][W-1:0]    req_data_i = '0;
  logic [N-1:0]           req_rdy_o;
  logic                   out_v_o;
  logic [W-1:0]           out_data_o;
  logic                   out_rdy_i = 1'b0;
  logic [CW-1:0]          out_credits_i = '0;
  logic                   fence_i = 1'b0;
  logic                   fence_done_o;
  logic [IW-1:0]          grant_id_o;
  logic [N-1:0][SW-1:0]   issued_count_o;
  logic [SW-1:0]          credit_stall_count_o;

  always #5 clk = ~clk;

  bsg_mcl_request_scheduler #(
    .num_req_p(N), .fifo_width_p(W), .max_out_credits_p(CRED), .stat_width_p(SW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_data_i(req_data_i), .req_rdy_o(req_rdy_o),
    .out_v_o(out_v_o), .out_data_o(out_data_o), .out_rdy_i(out_rdy_i),
    .out_credits_i(out_credits_i), .fence_i(fence_i), .fence_done_o(fence_done_o),
    .grant_id_o(grant_id_o), .issued_count_o(issued_count_o),
    .credit_stall_count_o(credit_stall_count_o)
  );

  typedef struct { logic [IW-1:0] id; logic [W-1:0] data; } pkt_t;
  pkt_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: what the endpoint-facing side should look like.
  int            m_state;
  int            m_last;
  bit            m_held;
  bit            m_sent;
  logic [SW-1:0] m_issued [N];
  logic [SW-1:0] m_stall;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_state = RUN;
    m_last  = N-1;
    m_held  = 1'b0;
    m_sent  = 1'b0;
    m_stall = '0;
    for (int i = 0; i < N; i++) m_issued[i] = '0;
  endfunction

  task automatic chk_stats();
    for (int i = 0; i < N; i++) begin
`ifdef BSG_MCL_SCHED_STATS_EN
      chk("issued_count", issued_count_o[i], m_issued[i]);
`else
      chk("issued_count", issued_count_o[i], '0);
`endif
    end
`ifdef BSG_MCL_SCHED_STATS_EN
    chk("credit_stall_count", credit_stall_count_o, m_stall);
`else
    chk("credit_stall_count", credit_stall_count_o, '0);
`endif
  endtask

  // One clock of stimulus. cred < 0 selects a random credit level.
  task automatic cycle(input int p_v, input int p_rdy, input int cred, input int p_fence);
    int         g;
    int         idx;
    int         pending;
    bit         free, ok, allow, stall, hs;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] d;
    @(negedge clk);
    reset_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_v_i[i]    = ($urandom_range(99) < p_v);
      req_data_i[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    out_rdy_i = ($urandom_range(99) < p_rdy);
    if (cred >= 0)                 out_credits_i = CW'(cred);
    else if ($urandom_range(1) == 0) out_credits_i = CW'(CRED);
    else                           out_credits_i = CW'($urandom_range(CRED));
    fence_i = ($urandom_range(99) < p_fence);
    #1;
    pending = int'(m_held) + int'(m_sent);
    free    = !m_held || out_rdy_i;
    ok      = int'(out_credits_i) > pending;
    allow   = (m_state == RUN) && !fence_i && free && ok;
    stall   = (m_state == RUN) && !fence_i && (req_v_i != '0) && free && !ok;
    g = -1;
    if (allow) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (g < 0 && bit'(req_v_i >> idx)) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy = N'(1) << g;
    chk("req_rdy", req_rdy_o, exp_rdy);
    chk("out_v", out_v_o, m_held);
    chk("fence_done", fence_done_o, m_state == DONE);
    if (g >= 0) begin
      d = '0;
      for (int i = 0; i < N; i++) if (i == g) d = req_data_i[i];
      sb.push_back('{IW'(g), d});
    end
    @(posedge clk);
    hs = m_held && out_rdy_i;
    case (m_state)
      RUN:     if (fence_i) m_state = FENCE;
      FENCE:   if (!m_held && !m_sent && int'(out_credits_i) == CRED) m_state = DONE;
      default: m_state = RUN;
    endcase
    if (g >= 0) begin
      m_held = 1'b1;
      m_last = g;
      m_issued[g] = m_issued[g] + 1;
    end else if (out_rdy_i) begin
      m_held = 1'b0;
    end
    m_sent = hs;
    if (stall) m_stall = m_stall + 1;
  endtask

  // Asynchronous reset asserted between edges while a packet is held; the
  // reset stays high through the next edge and is released by cycle().
  task automatic mid_reset();
    @(negedge clk);
    req_v_i       = '1;
    out_rdy_i     = 1'b1;
    out_credits_i = CW'(CRED);
    fence_i       = 1'b0;
    #3;
    chk("pre_reset_out_v", out_v_o, 1'b1);
    reset_i = 1'b1;
    #1;
    chk("rst_out_v", out_v_o, 1'b0);
    chk("rst_req_rdy", req_rdy_o, '0);
    chk("rst_out_data", out_data_o, '0);
    chk("rst_fence_done", fence_done_o, 1'b0);
    sb.delete();
    model_reset();
    chk_stats();
    @(posedge clk);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    pkt_t p;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_i && out_v_o && out_rdy_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_v", out_v_o, 1'b0);
        end else begin
          p = sb.pop_front();
          chk("out_data", out_data_o, p.data);
          chk("grant_id", grant_id_o, p.id);
        end
      end
    end
  end

  initial begin
    model_reset();
    #1 reset_i = 1'b1;
    #1;
    chk("rst_out_v", out_v_o, 1'b0);
    chk("rst_out_data", out_data_o, '0);
    chk("rst_grant_id", grant_id_o, '0);
    chk("rst_req_rdy", req_rdy_o, '0);
    chk("rst_fence_done", fence_done_o, 1'b0);
    chk_stats();
    @(posedge clk);

    // fairness: everyone valid, full credits, no backpressure
    repeat (8) cycle(100, 100, CRED, 0);
    chk_stats();
    // credit 1, then credit starvation
    repeat (6) cycle(100, 100, 1, 0);
    repeat (5) cycle(100, 100, 0, 0);
    chk_stats();
    // backpressure then release
    repeat (3) cycle(100, 0, CRED, 0);
    repeat (2) cycle(100, 100, CRED, 0);
    // fence with a packet held and credits partly out
    cycle(100, 0, 14, 100);
    repeat (6) cycle(100, 100, CRED, 0);
    chk_stats();
    // random traffic
    repeat (400) cycle(60, 70, -1, 5);
    chk_stats();
    // drain to RUN, load a packet, then reset mid-stream
    repeat (4) cycle(0, 100, CRED, 0);
    repeat (2) cycle(100, 0, CRED, 0);
    mid_reset();
    repeat (200) cycle(70, 60, -1, 4);
    chk_stats();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bsg_mcl_request_scheduler.md
# bsg_mcl_request_scheduler

Round-robin scheduler that shares the single host-to-manycore request FIFO channel of one endpoint among `num_req_p` host request queues. It gates issue against the endpoint's outstanding-credit count and provides a fence handshake that drains all in-flight requests. It sits between the host-side request queues and the endpoint's request-FIFO input (`fifo_v_i[2*i]` / `fifo_data_i[2*i]` / `fifo_rdy_o[2*i]`), and consumes that endpoint's `out_credits_o`.

## Interface
Parameters:
- `num_req_p`, 2: number of requesters; must be ≥ 2.
- `fifo_width_p`, 128: request packet width; the payload is opaque to this block.
- `max_out_credits_p`, 16: endpoint credit capacity.
- `credits_width_lp`, `$clog2(max_out_credits_p+1)`: credit count width (localparam).
- `stat_width_p`, 32: statistics counter width.

Ports:
- `clk_i`  in  1  sole clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `req_v_i`  in  `num_req_p`  per-requester valid.
- `req_data_i`  in  `num_req_p` x `fifo_width_p`  per-requester packet.
- `req_rdy_o`  out  `num_req_p`  one-hot-or-zero grant/ready.
- `out_v_o`  out  1  packet valid toward the endpoint request FIFO.
- `out_data_o`  out  `fifo_width_p`  packet toward the endpoint.
- `out_rdy_i`  in  1  endpoint ready.
- `out_credits_i`  in  `credits_width_lp`  endpoint outstanding credits.
- `fence_i`  in  1  fence request (level).
- `fence_done_o`  out  1  one-cycle pulse when the fence completes.
- `grant_id_o`  out  `$clog2(num_req_p)`  requester index of the packet in `out_data_o`.
- `issued_count_o`  out  `num_req_p` x `stat_width_p`  per-requester issued packets.
- `credit_stall_count_o`  out  `stat_width_p`  credit-stall cycles.

## Operation
- The output stage is a one-entry register holding `out_v_o`, `out_data_o` and `grant_id_o`.
- The slot is free when `!out_v_o || out_rdy_i`.
- `sent_r` is 1 for the cycle after each `out_v_o & out_rdy_i` handshake. It covers the one-cycle lag before the endpoint decrements its credits.
- Credit check: `out_credits_i > out_v_o + sent_r`. Compare as a 2-bit sum zero-extended to `credits_width_lp`.
- A grant is allowed when all of the following hold: state is RUN, `fence_i` is low, the slot is free, and the credit check passes.
- Round robin:
  - Pointer `last_r` holds the most recently granted index.
  - The grant goes to the first index with `req_v_i` set, searching from `last_r+1` upward modulo `num_req_p`.
  - Only that index sees `req_rdy_o` high. The transfer occurs when `req_v_i & req_rdy_o`.
  - `last_r` updates only on a transfer.
- FSM:
  - RUN → FENCE when `fence_i` is high. No grant is issued in that cycle.
  - FENCE → DONE when `out_v_o == 0`, `sent_r == 0` and `out_credits_i == max_out_credits_p`.
  - DONE → RUN unconditionally.
  - `fence_done_o = (state == DONE)`.
  - `fence_i` is ignored in FENCE and DONE. If it is still high in RUN, a new fence starts.
- Arithmetic: statistics counters wrap modulo 2^`stat_width_p`.

## Timing
- Reset values (asynchronous): `out_v_o=0`, `out_data_o=0`, `grant_id_o=0`, `req_rdy_o=0`, `fence_done_o=0`, state=RUN, `last_r=num_req_p-1` (requester 0 has first priority), `sent_r=0`, all counters 0.
- `req_rdy_o` is combinational from `req_v_i`, `out_rdy_i`, `out_credits_i`, `fence_i` and registered state. It never depends on `req_data_i`.
- Latency: a transfer at edge N gives `out_v_o=1` from cycle N+1.
- Throughput: 1 packet/cycle while credits allow (back-to-back when the slot drains in the same cycle it reloads).
- `out_v_o` and `out_data_o` hold stable until `out_rdy_i`. No retraction.
- Credits:
  - At most `out_credits_i - out_v_o - sent_r` more packets are granted, so the endpoint never sees an over-issue.
  - With `out_credits_i == 0`, no grants.
- Reset mid-operation drops the held packet. `fence_done_o` is never asserted after reset until a new fence completes.

## Configuration
- `BSG_MCL_SCHED_STATS_EN`
  - Defined:
    - `issued_count_o[i]` increments on each requester-i transfer.
    - `credit_stall_count_o` increments each cycle where state is RUN, `fence_i` is low, some `req_v_i` is set, the slot is free and the credit check fails.
  - Undefined: both outputs are constant 0 and no counter flops are instantiated. Scheduling behaviour is identical.

## Test plan
- Single requester: after reset, `req_v_i=2'b01`, credits 16, `out_rdy_i=1` → `req_rdy_o=01` in the first cycle; `out_v_o=1` with matching data and `grant_id_o=0` the next cycle.
- Fairness: both requesters always valid, credits 16, `out_rdy_i=1` → grants alternate 0,1,0,1 for 8 cycles; `issued_count_o` = {4,4} (STATS_EN).
- Credit gate: hold `out_credits_i=1`, `out_rdy_i=1` → exactly one grant; no further `req_rdy_o` while `sent_r` or `out_v_o` is pending. With credits 0 and a request pending for 5 cycles → `credit_stall_count_o=5`.
- Backpressure: `out_rdy_i=0` for 3 cycles with a packet held → `out_data_o` stable and `req_rdy_o=0` for all 3 cycles; raising `out_rdy_i` completes the handshake and reloads in the same cycle.
- Fence: pulse `fence_i` with a packet held and credits 14, then return credits to 16 → no grants during FENCE; `fence_done_o` is high exactly one cycle after the drain condition is met; grants resume in RUN.
- Async reset mid-stream: assert `reset_i` between clock edges while `out_v_o=1` → `out_v_o`, `req_rdy_o` and counters go to 0 immediately; after release, requester 0 is granted first.
